// File: rtl/alu_result_stage.sv
// alu_result_stage: EX->MEM stage with a 2-entry skid buffer and a precise overflow trap.
// Define OVF_TRAP_EN to enable the overflow trap and its RUN/TRAP FSM.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int RW = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_aluout,
  input  logic             in_overflow,
  input  logic             in_unsig,
  input  logic [RW-1:0]    in_rd,
  input  logic             in_regwrite,
  input  logic [WIDTH-1:0] in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_aluout,
  output logic [RW-1:0]    out_rd,
  output logic             out_regwrite,
  output logic             exc_valid,
  output logic [WIDTH-1:0] exc_pc,
  input  logic             exc_ack
);
  typedef struct packed {
    logic [WIDTH-1:0] aluout;
    logic [RW-1:0]    rd;
    logic             regwrite;
  } entry_t;
  logic [1:0] count;
  entry_t head, tail, new_e;
  logic accept, trap, push, pop, run;
  assign new_e = '{aluout: in_aluout, rd: in_rd, regwrite: in_regwrite};
  assign out_valid = count != 2'd0;
  assign {out_aluout, out_rd, out_regwrite} = head;
  assign accept = in_valid & in_ready;
  assign push = accept & ~trap;
  assign pop = out_valid & out_ready;
  assign in_ready = (count < 2'd2) & run & reset;
`ifdef OVF_TRAP_EN
  typedef enum logic {RUN, TRAP} state_t;
  state_t state, state_next;
  assign trap = accept & in_overflow & ~in_unsig;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= RUN;
      exc_pc <= '0;
    end else begin
      state <= state_next;
      if (trap) exc_pc <= in_pc;
    end
  end
  always_comb begin
    state_next = state;
    if (state == RUN && trap) state_next = TRAP;
    else if (state == TRAP && exc_ack) state_next = RUN;
  end
  always_comb begin
    run = state == RUN;
    exc_valid = state == TRAP;
  end
`else
  logic unused;
  assign unused = &{1'b0, in_overflow, in_unsig, in_pc, exc_ack};
  assign trap = 1'b0;
  assign run = 1'b1;
  assign exc_valid = 1'b0;
  assign exc_pc = '0;
`endif
  // The head slot always holds the oldest entry; a pop shifts the tail forward.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (pop) head <= (count == 2'd2) ? tail : new_e;
      else if (push && count == 2'd0) head <= new_e;
      if (push && !pop && count == 2'd1) tail <= new_e;
    end
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed test of alu_result_stage against a queue-based model.
module tb_alu_result_stage;
  logic clock = 0, reset = 0;
  logic in_valid = 0, in_overflow = 0, in_unsig = 0, in_regwrite = 0;
  logic [31:0] in_aluout = 0, in_pc = 0;
  logic [4:0] in_rd = 0;
  logic out_ready = 0, exc_ack = 0;
  logic in_ready, out_valid, out_regwrite, exc_valid;
  logic [31:0] out_aluout, exc_pc;
  logic [4:0] out_rd;
  int pass_cnt = 0, total_cnt = 0;
  bit started = 0;

  alu_result_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluout(in_aluout), .in_overflow(in_overflow), .in_unsig(in_unsig),
    .in_rd(in_rd), .in_regwrite(in_regwrite), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluout(out_aluout),
    .out_rd(out_rd), .out_regwrite(out_regwrite), .exc_valid(exc_valid),
    .exc_pc(exc_pc), .exc_ack(exc_ack));

  always #5 clock = ~clock;

  typedef struct { logic [31:0] a; logic [4:0] rd; logic rw; } ent_t;
  ent_t q[$];
  logic m_exc = 0;
  logic [31:0] m_pc = 0;

  function automatic logic m_ready();
    return reset && q.size() < 2 && !m_exc;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Model: FIFO of at most two results, trap flag held until acknowledged.
  always @(posedge clock) begin
    if (!reset) begin
      q.delete();
      m_exc = 0;
      m_pc = 0;
    end else begin
      bit acc, pop, trp;
      acc = in_valid && m_ready();
      pop = q.size() != 0 && out_ready;
`ifdef OVF_TRAP_EN
      trp = acc && in_overflow && !in_unsig;
`else
      trp = 0;
`endif
      if (m_exc && exc_ack) m_exc = 0;
      if (pop) void'(q.pop_front());
      if (trp) begin
        m_exc = 1;
        m_pc = in_pc;
      end else if (acc) q.push_back('{in_aluout, in_rd, in_regwrite});
    end
  end

  always @(negedge clock) if (started) begin
    chk("in_ready", in_ready, m_ready());
    chk("out_valid", out_valid, q.size() != 0);
    chk("exc_valid", exc_valid, m_exc);
    chk("exc_pc", exc_pc, m_pc);
    if (q.size() != 0) begin
      chk("out_aluout", out_aluout, q[0].a);
      chk("out_rd", out_rd, q[0].rd);
      chk("out_regwrite", out_regwrite, q[0].rw);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] a, logic [4:0] rd, logic rw);
    in_valid = v; in_aluout = a; in_rd = rd; in_regwrite = rw;
  endtask

  initial begin
    tick();
    started = 1;
    tick();
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_aluout", out_aluout, 0);
    chk("rst exc_valid", exc_valid, 0);
    chk("rst exc_pc", exc_pc, 0);
    reset = 1;
    #1 chk("in_ready after rst", in_ready, 1);
    // 1: single result through an empty buffer
    out_ready = 1;
    drive(1, 32'h5, 5'd3, 1);
    tick();
    drive(0, 0, 0, 0);
    chk("t1 out_valid", out_valid, 1);
    chk("t1 out_aluout", out_aluout, 32'h5);
    chk("t1 out_rd", out_rd, 3);
    tick();
    chk("t1 drained", out_valid, 0);
    // 2: fill, stall, drain in order
    out_ready = 0;
    drive(1, 32'hA, 5'd1, 1);
    tick();
    drive(1, 32'hB, 5'd2, 1);
    tick();
    chk("t2 full in_ready", in_ready, 0);
    drive(1, 32'hC, 5'd4, 0);
    tick();
    chk("t2 stall in_ready", in_ready, 0);
    chk("t2 head A", out_aluout, 32'hA);
    out_ready = 1;
    tick();
    chk("t2 head B", out_aluout, 32'hB);
    tick();
    drive(0, 0, 0, 0);
    chk("t2 head C", out_aluout, 32'hC);
    chk("t2 C regwrite", out_regwrite, 0);
    tick();
    chk("t2 empty", out_valid, 0);
    // 3: simultaneous push and pop with one entry held
    out_ready = 0;
    drive(1, 32'hD, 5'd5, 1);
    tick();
    out_ready = 1;
    drive(1, 32'hE, 5'd6, 1);
    tick();
    drive(0, 0, 0, 0);
    chk("t3 out_valid", out_valid, 1);
    chk("t3 head E", out_aluout, 32'hE);
    tick();
    chk("t3 empty", out_valid, 0);
    // 5: unsigned overflow is pushed normally
    out_ready = 0;
    in_overflow = 1; in_unsig = 1;
    drive(1, 32'h8000_0000, 5'd7, 0);
    tick();
    drive(0, 0, 0, 0);
    in_overflow = 0; in_unsig = 0;
    chk("t5 out_valid", out_valid, 1);
    chk("t5 out_aluout", out_aluout, 32'h8000_0000);
    chk("t5 regwrite", out_regwrite, 0);
    chk("t5 no exc", exc_valid, 0);
    // 4: signed overflow
    in_overflow = 1; in_unsig = 0; in_pc = 32'h0040_0010;
    drive(1, 32'h7, 5'd8, 1);
    tick();
    drive(0, 0, 0, 0);
    in_overflow = 0;
`ifdef OVF_TRAP_EN
    chk("t4 exc_valid", exc_valid, 1);
    chk("t4 exc_pc", exc_pc, 32'h0040_0010);
    chk("t4 in_ready", in_ready, 0);
    chk("t4 head unchanged", out_aluout, 32'h8000_0000);
    tick();
    chk("t4 exc held", exc_valid, 1);
    // 6: reset with one entry and a trap pending
    reset = 0;
    tick();
`else
    chk("t4 pushed head", out_aluout, 32'h8000_0000);
    chk("t4 no exc", exc_valid, 0);
    chk("t4 full", in_ready, 0);
    // 6: reset with two entries buffered
    reset = 0;
    tick();
`endif
    chk("t6 out_valid", out_valid, 0);
    chk("t6 exc_valid", exc_valid, 0);
    chk("t6 exc_pc", exc_pc, 0);
    chk("t6 in_ready", in_ready, 0);
    reset = 1;
    #1 chk("t6 in_ready up", in_ready, 1);
`ifdef OVF_TRAP_EN
    // trap then acknowledge; an ack while idle is ignored
    exc_ack = 1;
    tick();
    exc_ack = 0;
    chk("ack idle", exc_valid, 0);
    in_overflow = 1; in_pc = 32'h0040_0020;
    drive(1, 32'h9, 5'd9, 1);
    tick();
    drive(0, 0, 0, 0);
    in_overflow = 0;
    chk("t4b exc_pc", exc_pc, 32'h0040_0020);
    exc_ack = 1;
    tick();
    exc_ack = 0;
    chk("t4b cleared", exc_valid, 0);
    chk("t4b in_ready", in_ready, 1);
`endif
    // mixed valid/ready patterns checked by the model every cycle
    for (int i = 0; i < 48; i++) begin
      drive(i[0] | i[3], 32'h100 + 32'(i), 5'(i), i[1]);
      out_ready = i[2] ^ i[4];
      in_overflow = (i % 11) == 5;
      in_unsig = i[1];
      in_pc = 32'h1000 + 32'(i * 4);
      exc_ack = (i % 7) == 3;
      tick();
    end
    drive(0, 0, 0, 0);
    in_overflow = 0; exc_ack = 1; out_ready = 1;
    tick();
    tick();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
